// File: rtl/guess_entry.sv
`default_nettype none
// ============================================================================
//  Module      : guess_entry
//  Description : Player-input front end for one Mastermind guess. Conditions
//                two push-buttons (synchronize + rising-edge detect), lets the
//                player step a digit 0..2^DIGIT_W-1 and advance across slots,
//                then offers the packed guess with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module guess_entry #(
  parameter  int NUM_SLOTS = 4,
  parameter  int DIGIT_W   = 3,
  localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic                         inc_key,
  input  logic                         next_key,
  input  logic                         guess_ready,
  output logic [DIGIT_W-1:0]           cur_digit,
  output logic [SLOT_W-1:0]            slot_idx,
  output logic [NUM_SLOTS*DIGIT_W-1:0] guess,
  output logic                         guess_valid
);

  localparam logic [SLOT_W-1:0] C_LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic [0:0] {
    S_ENTRY    = 1'b0,
    S_WAIT_ACK = 1'b1
  } state_t;

  // Bit 0 = inc key, bit 1 = next key.
  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic [1:0] r_prev;
  logic [1:0] w_pulse;
  logic       w_inc_pulse;
  logic       w_next_pulse;

  state_t                         r_state;
  logic [DIGIT_W-1:0]             r_digit;
  logic [SLOT_W-1:0]              r_slot;
  logic [NUM_SLOTS*DIGIT_W-1:0]   r_guess;
  logic                           r_valid;

  // Two-flop synchronizer followed by a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= {next_key, inc_key};
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // One-cycle press pulse per synchronized rising edge; holding gives no repeat.
  assign w_pulse      = r_s2 & ~r_prev;
  assign w_inc_pulse  = w_pulse[0];
  assign w_next_pulse = w_pulse[1];

  // Entry / handshake state machine; all outputs come straight from these flops.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= S_ENTRY;
      r_digit <= '0;
      r_slot  <= '0;
      r_guess <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_ENTRY: begin
          // A next press wins over a coincident inc press.
          if (w_next_pulse) begin
            r_guess[r_slot*DIGIT_W +: DIGIT_W] <= r_digit;
            if (r_slot == C_LAST_SLOT) begin
              r_state <= S_WAIT_ACK;
              r_valid <= 1'b1;
            end else begin
              r_slot  <= r_slot + SLOT_W'(1);
              r_digit <= '0;
            end
          end else if (w_inc_pulse) begin
            r_digit <= r_digit + DIGIT_W'(1);
          end
        end
        S_WAIT_ACK: begin
          // Everything frozen until the controller takes the guess.
          if (r_valid && guess_ready) begin
            r_state <= S_ENTRY;
            r_digit <= '0;
            r_slot  <= '0;
            r_guess <= '0;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_ENTRY;
        end
      endcase
    end
  end

  assign cur_digit   = r_digit;
  assign slot_idx    = r_slot;
  assign guess       = r_guess;
  assign guess_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_guess_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_guess_entry
//  Description : Directed self-checking bench for guess_entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_guess_entry;

  logic        clk = 1'b0;
  logic        Reset;
  logic        inc_key;
  logic        next_key;
  logic        guess_ready;
  logic [2:0]  cur_digit;
  logic [1:0]  slot_idx;
  logic [11:0] guess;
  logic        guess_valid;

  int n_checks = 0;
  int n_fail   = 0;

  guess_entry #(.NUM_SLOTS(4), .DIGIT_W(3)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .inc_key     (inc_key),
    .next_key    (next_key),
    .guess_ready (guess_ready),
    .cur_digit   (cur_digit),
    .slot_idx    (slot_idx),
    .guess       (guess),
    .guess_valid (guess_valid)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raw press: keys high for hi cycles then low for lo cycles.
  task automatic press(input logic inc, input logic nxt, input int hi = 4, input int lo = 4);
    inc_key  = inc;
    next_key = nxt;
    tick(hi);
    inc_key  = 1'b0;
    next_key = 1'b0;
    tick(lo);
  endtask

  task automatic press_n(input int n);
    for (int i = 0; i < n; i++) press(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    Reset       = 1'b1;
    inc_key     = 1'b0;
    next_key    = 1'b0;
    guess_ready = 1'b0;
    tick(2);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({cur_digit, slot_idx, guess, guess_valid} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_state: digit=%0d slot=%0d guess=%o valid=%b, required all 0",
               cur_digit, slot_idx, guess, guess_valid);
    end
  endtask

  task automatic test_inc();
    logic [2:0] exp_d;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      exp_d   = 3'(i + 1);
      inc_key = 1'b1;
      tick(2);
      n_checks++;
      if (cur_digit !== 3'(i)) begin
        n_fail++;
        $display("FAIL inc_early[%0d]: digit=%0d required %0d", i, cur_digit, 3'(i));
      end
      tick(1);
      n_checks++;
      if (cur_digit !== exp_d) begin
        n_fail++;
        $display("FAIL inc_step[%0d]: digit=%0d required %0d", i, cur_digit, exp_d);
      end
      tick(1);
      inc_key = 1'b0;
      tick(4);
    end
    n_checks++;
    if (cur_digit !== 3'd1) begin
      n_fail++;
      $display("FAIL inc_final: digit=%0d required 1", cur_digit);
    end
  endtask

  // Leaves a complete guess 3,5,0,7 pending for the handshake test.
  task automatic test_entry();
    do_reset();
    press_n(3);
    press(1'b0, 1'b1);
    n_checks++;
    if ({guess, slot_idx, cur_digit, guess_valid} !== {12'o0003, 2'd1, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL entry_slot0: guess=%o slot=%0d digit=%0d valid=%b, required 0003/1/0/0",
               guess, slot_idx, cur_digit, guess_valid);
    end
    press_n(5);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    n_checks++;
    if ({guess, slot_idx, cur_digit} !== {12'o0053, 2'd3, 3'd0}) begin
      n_fail++;
      $display("FAIL entry_slot2: guess=%o slot=%0d digit=%0d, required 0053/3/0",
               guess, slot_idx, cur_digit);
    end
    press_n(7);
    press(1'b0, 1'b1);
    n_checks++;
    if ({guess, slot_idx, cur_digit, guess_valid} !== {12'o7053, 2'd3, 3'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL entry_done: guess=%o slot=%0d digit=%0d valid=%b, required 7053/3/7/1",
               guess, slot_idx, cur_digit, guess_valid);
    end
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    n_checks++;
    if ({guess, slot_idx, cur_digit, guess_valid} !== {12'o7053, 2'd3, 3'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL wait_frozen: guess=%o slot=%0d digit=%0d valid=%b, required 7053/3/7/1",
               guess, slot_idx, cur_digit, guess_valid);
    end
  endtask

  task automatic test_handshake();
    guess_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      n_checks++;
      if ({guess_valid, guess} !== {1'b1, 12'o7053}) begin
        n_fail++;
        $display("FAIL hs_hold[%0d]: valid=%b guess=%o, required 1/7053", i, guess_valid, guess);
      end
    end
    guess_ready = 1'b1;
    #2;
    n_checks++;
    if (guess_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_comb_path: valid=%b before edge, required 1", guess_valid);
    end
    tick(1);
    guess_ready = 1'b0;
    n_checks++;
    if ({guess_valid, guess, slot_idx, cur_digit} !== 18'h0) begin
      n_fail++;
      $display("FAIL hs_transfer: valid=%b guess=%o slot=%0d digit=%0d, required all 0",
               guess_valid, guess, slot_idx, cur_digit);
    end
  endtask

  // Ready high throughout entry: ignored until valid, then one-cycle transfer.
  task automatic test_ready_early();
    do_reset();
    guess_ready = 1'b1;
    press_n(1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    n_checks++;
    if ({slot_idx, guess, guess_valid} !== {2'd3, 12'o0001, 1'b0}) begin
      n_fail++;
      $display("FAIL early_ready_entry: slot=%0d guess=%o valid=%b, required 3/0001/0",
               slot_idx, guess, guess_valid);
    end
    next_key = 1'b1;
    tick(3);
    n_checks++;
    if ({guess_valid, guess} !== {1'b1, 12'o0001}) begin
      n_fail++;
      $display("FAIL early_ready_valid: valid=%b guess=%o, required 1/0001", guess_valid, guess);
    end
    tick(1);
    n_checks++;
    if ({guess_valid, guess} !== {1'b0, 12'o0000}) begin
      n_fail++;
      $display("FAIL early_ready_xfer: valid=%b guess=%o, required 0/0000", guess_valid, guess);
    end
    next_key    = 1'b0;
    guess_ready = 1'b0;
    tick(4);
  endtask

  task automatic test_coincident();
    do_reset();
    press_n(2);
    press(1'b0, 1'b1);
    press_n(2);
    press(1'b1, 1'b1);
    n_checks++;
    if ({guess, slot_idx, cur_digit} !== {12'o0022, 2'd2, 3'd0}) begin
      n_fail++;
      $display("FAIL coincident: guess=%o slot=%0d digit=%0d, required 0022/2/0",
               guess, slot_idx, cur_digit);
    end
    press(1'b1, 1'b0, 20, 4);
    n_checks++;
    if (cur_digit !== 3'd1) begin
      n_fail++;
      $display("FAIL hold_one_pulse: digit=%0d required 1", cur_digit);
    end
  endtask

  task automatic test_reset_wait_ack();
    do_reset();
    press_n(1);
    for (int i = 0; i < 4; i++) press(1'b0, 1'b1);
    n_checks++;
    if ({guess_valid, guess} !== {1'b1, 12'o0001}) begin
      n_fail++;
      $display("FAIL rst_wait_setup: valid=%b guess=%o, required 1/0001", guess_valid, guess);
    end
    Reset = 1'b1;
    tick(1);
    n_checks++;
    if ({cur_digit, slot_idx, guess, guess_valid} !== 18'h0) begin
      n_fail++;
      $display("FAIL rst_in_wait: digit=%0d slot=%0d guess=%o valid=%b, required all 0",
               cur_digit, slot_idx, guess, guess_valid);
    end
    // Key held across reset release gives exactly one press two edges later.
    inc_key = 1'b1;
    tick(2);
    Reset = 1'b0;
    tick(2);
    n_checks++;
    if (cur_digit !== 3'd0) begin
      n_fail++;
      $display("FAIL held_rel_early: digit=%0d required 0", cur_digit);
    end
    tick(1);
    n_checks++;
    if (cur_digit !== 3'd1) begin
      n_fail++;
      $display("FAIL held_rel_press: digit=%0d required 1", cur_digit);
    end
    tick(6);
    inc_key = 1'b0;
    tick(4);
    n_checks++;
    if (cur_digit !== 3'd1) begin
      n_fail++;
      $display("FAIL held_rel_once: digit=%0d required 1", cur_digit);
    end
  endtask

  task automatic test_reset_mid_entry();
    do_reset();
    press_n(2);
    press(1'b0, 1'b1);
    press_n(3);
    press(1'b0, 1'b1);
    press_n(1);
    n_checks++;
    if ({guess, slot_idx, cur_digit} !== {12'o0032, 2'd2, 3'd1}) begin
      n_fail++;
      $display("FAIL mid_setup: guess=%o slot=%0d digit=%0d, required 0032/2/1",
               guess, slot_idx, cur_digit);
    end
    Reset = 1'b1;
    inc_key = 1'b1;
    next_key = 1'b1;
    tick(1);
    n_checks++;
    if ({cur_digit, slot_idx, guess, guess_valid} !== 18'h0) begin
      n_fail++;
      $display("FAIL rst_mid_entry: digit=%0d slot=%0d guess=%o valid=%b, required all 0",
               cur_digit, slot_idx, guess, guess_valid);
    end
    inc_key  = 1'b0;
    next_key = 1'b0;
    tick(1);
    Reset = 1'b0;
    tick(4);
  endtask

  initial begin
    Reset       = 1'b1;
    inc_key     = 1'b0;
    next_key    = 1'b0;
    guess_ready = 1'b0;
    test_reset();
    test_inc();
    test_entry();
    test_handshake();
    test_ready_early();
    test_coincident();
    test_reset_wait_ack();
    test_reset_mid_entry();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
